// File: rtl/aes_pkg.sv
// Shared AES-128 constants, byte tables and GF(2^8) helpers for the cipher blocks.
package aes_pkg;

  localparam int NR = 10;

  typedef enum logic [2:0] {
    IDLE,
    KEYEXP,
    ADDK,
    ROUND,
    LAST,
    DONE
  } state_t;

  // Index 0 lands in the most significant byte of each concatenation.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  localparam logic [0:9][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then
// InvMixColumns unless this is the final round.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] st,
  input  logic [127:0] rk,
  input  logic         last,
  output logic [127:0] next_st
);

  logic [7:0] in_b [16];
  logic [7:0] ark  [16];

  // Byte 4*c+r sits at row r of column c; row r rotates right by r positions.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      in_b[i] = st[127 - 8*i -: 8];
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        ark[4*c + r] = INV_SBOX[in_b[4*((c - r + 4) % 4) + r]] ^ rk[127 - 8*(4*c + r) -: 8];
      end
    end
  end

  always_comb begin : mix
    logic [7:0] a0, a1, a2, a3;
    next_st = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = ark[4*c];
      a1 = ark[4*c + 1];
      a2 = ark[4*c + 2];
      a3 = ark[4*c + 3];
      if (last) begin
        next_st[127 - 32*c -: 32] = {a0, a1, a2, a3};
      end else begin
        next_st[127 - 32*c -: 8]  = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
        next_st[119 - 32*c -: 8]  = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
        next_st[111 - 32*c -: 8]  = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
        next_st[103 - 32*c -: 8]  = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
      end
    end
  end

endmodule

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 inverse cipher: expands the cipher key forward to rk10, then
// decrypts one round per cycle while walking the key schedule backwards.
module aes_inv_cipher
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] datain,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] dataout,
  output logic         busy
);

  localparam logic [3:0] CNT_MAX = 4'(NR - 1);

  state_t       state, state_next;
  logic [127:0] ct_reg;
  logic [127:0] key_reg;
  logic [127:0] st_reg;
  logic [127:0] round_out;
  logic [3:0]   cnt;
  logic [3:0]   rcon_idx;
  logic [7:0]   rcon;

  function automatic logic [127:0] fwd_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ sub_word(rot_word(k[31:0])) ^ {rc, 24'h0};
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Undoes fwd_key: the older w3 is recovered first since it feeds the SubWord term.
  function automatic logic [127:0] inv_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n3 = k[31:0] ^ k[63:32];
    n2 = k[63:32] ^ k[95:64];
    n1 = k[95:64] ^ k[127:96];
    n0 = k[127:96] ^ sub_word(rot_word(n3)) ^ {rc, 24'h0};
    return {n0, n1, n2, n3};
  endfunction

  aes_inv_round u_round (
    .st      (st_reg),
    .rk      (key_reg),
    .last    (state == LAST),
    .next_st (round_out)
  );

  // Going back from rk_i to rk_(i-1) needs the Rcon that originally produced rk_i.
  always_comb begin
    rcon_idx = (state == ROUND) ? (cnt - 4'd1) : cnt;
    rcon     = (rcon_idx <= CNT_MAX) ? RCON[rcon_idx] : 8'h00;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = KEYEXP;
      KEYEXP:  if (cnt == CNT_MAX) state_next = ADDK;
      ADDK:    state_next = ROUND;
      ROUND:   if (cnt == 4'd1) state_next = LAST;
      LAST:    state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ct_reg  <= '0;
      key_reg <= '0;
      st_reg  <= '0;
      cnt     <= '0;
      dataout <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            ct_reg  <= datain;
            key_reg <= key;
            cnt     <= '0;
          end
        end
        KEYEXP: begin
          key_reg <= fwd_key(key_reg, rcon);
          if (cnt != CNT_MAX) cnt <= cnt + 4'd1;
        end
        ADDK: begin
          st_reg  <= ct_reg ^ key_reg;
          key_reg <= inv_key(key_reg, rcon);
        end
        ROUND: begin
          st_reg  <= round_out;
          key_reg <= inv_key(key_reg, rcon);
          cnt     <= cnt - 4'd1;
        end
        LAST: begin
          dataout <= round_out;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

endmodule
